// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: response codes and the state encodings of the
// non-burst slave's write and read FSMs.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_EXEC,
        W_WAIT,
        W_RESP,
        W_DRAIN
    } wState_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP,
        R_ERR
    } rState_e;

endpackage

// File: rtl/axi4_noburst_slave_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between a non-burst master and the slave.
interface axi4_noburst_slave_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = 4
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [IW-1:0]   S_AXI_AWID;
    logic [7:0]      S_AXI_AWLEN;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;

    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WLAST;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;

    logic [1:0]      S_AXI_BRESP;
    logic [IW-1:0]   S_AXI_BID;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;

    logic [AW-1:0]   S_AXI_ARADDR;
    logic [IW-1:0]   S_AXI_ARID;
    logic [7:0]      S_AXI_ARLEN;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;

    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic [IW-1:0]   S_AXI_RID;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RID, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RID, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/axi4_noburst_slave.sv
// Single-beat AXI4 responder: turns AW/W and AR into one-cycle user strobes and
// returns the user's completion as B/R; bursts are drained and answered SLVERR.
module axi4_noburst_slave
    import axi4_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = 4
) (
    input  logic            clk,
    input  logic            resetn,
    axi4_noburst_slave_if.slave s_axi,

    output logic [AW-1:0]   U_WADDR,
    output logic [DW-1:0]   U_WDATA,
    output logic [DW/8-1:0] U_WSTRB,
    output logic            U_WRITE,
    input  logic            U_WDONE,
    input  logic [1:0]      U_WRESP,

    output logic [AW-1:0]   U_RADDR,
    output logic            U_READ,
    input  logic            U_RDONE,
    input  logic [DW-1:0]   U_RDATA,
    input  logic [1:0]      U_RRESP
);

    wState_e         wState_q;
    logic            awReady_q, wReady_q, awGot_q, wGot_q;
    logic [AW-1:0]   awAddr_q;
    logic [IW-1:0]   awId_q;
    logic [7:0]      awLen_q;
    logic [DW-1:0]   wData_q;
    logic [DW/8-1:0] wStrb_q;
    logic            wLast_q;
    logic            uWrite_q, bValid_q;
    logic [1:0]      bResp_q;
    logic [IW-1:0]   bId_q;

    rState_e         rState_q;
    logic            arReady_q, uRead_q, rValid_q, rLast_q;
    logic [AW-1:0]   arAddr_q;
    logic [IW-1:0]   arId_q;
    logic [7:0]      arLen_q, rCnt_q;
    logic [DW-1:0]   rData_q;
    logic [1:0]      rResp_q;
    logic [IW-1:0]   rId_q;

    logic            awHs, wHs, arHs;
    logic            awGot_d, wGot_d, wLast_d;
    logic [7:0]      awLen_d;
    logic [IW-1:0]   awId_d;

    assign awHs = s_axi.S_AXI_AWVALID & awReady_q;
    assign wHs  = s_axi.S_AXI_WVALID  & wReady_q;
    assign arHs = s_axi.S_AXI_ARVALID & arReady_q;

    // View of the AW/W capture including whatever handshakes this cycle
    assign awGot_d = awGot_q | awHs;
    assign wGot_d  = wGot_q  | wHs;
    assign awLen_d = awHs ? s_axi.S_AXI_AWLEN : awLen_q;
    assign awId_d  = awHs ? s_axi.S_AXI_AWID  : awId_q;
    assign wLast_d = wHs  ? s_axi.S_AXI_WLAST : wLast_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wState_q  <= W_IDLE;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            awGot_q   <= 1'b0;
            wGot_q    <= 1'b0;
            awAddr_q  <= '0;
            awId_q    <= '0;
            awLen_q   <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            wLast_q   <= 1'b0;
            uWrite_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bResp_q   <= RESP_OKAY;
            bId_q     <= '0;
        end else begin
            uWrite_q <= 1'b0;
            case (wState_q)
                W_IDLE: begin
                    if (awHs) begin
                        awAddr_q <= s_axi.S_AXI_AWADDR;
                        awId_q   <= s_axi.S_AXI_AWID;
                        awLen_q  <= s_axi.S_AXI_AWLEN;
                        awGot_q  <= 1'b1;
                    end
                    if (wHs) begin
                        wData_q <= s_axi.S_AXI_WDATA;
                        wStrb_q <= s_axi.S_AXI_WSTRB;
                        wLast_q <= s_axi.S_AXI_WLAST;
                        wGot_q  <= 1'b1;
                    end
                    awReady_q <= ~awGot_d;
                    wReady_q  <= ~wGot_d;
                    if (awGot_d && wGot_d) begin
                        awGot_q <= 1'b0;
                        wGot_q  <= 1'b0;
                        if (awLen_d == 8'd0) begin
                            uWrite_q <= 1'b1;
                            wState_q <= W_EXEC;
                        end else if (wLast_d) begin
                            bValid_q <= 1'b1;
                            bResp_q  <= RESP_SLVERR;
                            bId_q    <= awId_d;
                            wState_q <= W_RESP;
                        end else begin
                            wReady_q <= 1'b1;
                            wState_q <= W_DRAIN;
                        end
                    end
                end
                W_EXEC: wState_q <= W_WAIT;
                W_WAIT: begin
                    if (U_WDONE) begin
                        bValid_q <= 1'b1;
                        bResp_q  <= U_WRESP;
                        bId_q    <= awId_q;
                        wState_q <= W_RESP;
                    end
                end
                W_DRAIN: begin
                    if (wHs && s_axi.S_AXI_WLAST) begin
                        wReady_q <= 1'b0;
                        bValid_q <= 1'b1;
                        bResp_q  <= RESP_SLVERR;
                        bId_q    <= awId_q;
                        wState_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bValid_q  <= 1'b0;
                        awReady_q <= 1'b1;
                        wReady_q  <= 1'b1;
                        wState_q  <= W_IDLE;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    // Burst reads count beats so RLAST lands on beat ARLEN+1
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rState_q  <= R_IDLE;
            arReady_q <= 1'b0;
            arAddr_q  <= '0;
            arId_q    <= '0;
            arLen_q   <= '0;
            rCnt_q    <= '0;
            uRead_q   <= 1'b0;
            rValid_q  <= 1'b0;
            rLast_q   <= 1'b0;
            rData_q   <= '0;
            rResp_q   <= RESP_OKAY;
            rId_q     <= '0;
        end else begin
            uRead_q <= 1'b0;
            case (rState_q)
                R_IDLE: begin
                    arReady_q <= 1'b1;
                    if (arHs) begin
                        arReady_q <= 1'b0;
                        arAddr_q  <= s_axi.S_AXI_ARADDR;
                        arId_q    <= s_axi.S_AXI_ARID;
                        arLen_q   <= s_axi.S_AXI_ARLEN;
                        if (s_axi.S_AXI_ARLEN == 8'd0) begin
                            uRead_q  <= 1'b1;
                            rState_q <= R_WAIT;
                        end else begin
                            rCnt_q   <= 8'd0;
                            rValid_q <= 1'b1;
                            rLast_q  <= 1'b0;
                            rData_q  <= '0;
                            rResp_q  <= RESP_SLVERR;
                            rId_q    <= s_axi.S_AXI_ARID;
                            rState_q <= R_ERR;
                        end
                    end
                end
                R_WAIT: begin
                    if (U_RDONE) begin
                        rData_q  <= U_RDATA;
                        rResp_q  <= U_RRESP;
                        rId_q    <= arId_q;
                        rLast_q  <= 1'b1;
                        rValid_q <= 1'b1;
                        rState_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rValid_q  <= 1'b0;
                        rLast_q   <= 1'b0;
                        arReady_q <= 1'b1;
                        rState_q  <= R_IDLE;
                    end
                end
                R_ERR: begin
                    if (s_axi.S_AXI_RREADY) begin
                        if (rLast_q) begin
                            rValid_q  <= 1'b0;
                            rLast_q   <= 1'b0;
                            arReady_q <= 1'b1;
                            rState_q  <= R_IDLE;
                        end else begin
                            rCnt_q  <= rCnt_q + 8'd1;
                            rLast_q <= ((rCnt_q + 8'd1) == arLen_q);
                        end
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awReady_q;
    assign s_axi.S_AXI_WREADY  = wReady_q;
    assign s_axi.S_AXI_BVALID  = bValid_q;
    assign s_axi.S_AXI_BRESP   = bResp_q;
    assign s_axi.S_AXI_BID     = bId_q;
    assign s_axi.S_AXI_ARREADY = arReady_q;
    assign s_axi.S_AXI_RVALID  = rValid_q;
    assign s_axi.S_AXI_RDATA   = rData_q;
    assign s_axi.S_AXI_RRESP   = rResp_q;
    assign s_axi.S_AXI_RID     = rId_q;
    assign s_axi.S_AXI_RLAST   = rLast_q;

    assign U_WADDR = awAddr_q;
    assign U_WDATA = wData_q;
    assign U_WSTRB = wStrb_q;
    assign U_WRITE = uWrite_q;
    assign U_RADDR = arAddr_q;
    assign U_READ  = uRead_q;

endmodule

// File: tb/tb_axi4_noburst_slave.sv
// Directed bench for axi4_noburst_slave: single writes/reads, ordering, back-
// pressure, burst rejection and mid-transaction reset.
module tb_axi4_noburst_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] uWaddr, uWdata, uRaddr, uRdata;
    logic [3:0]  uWstrb;
    logic        uWrite, uWdone, uRead, uRdone;
    logic [1:0]  uWresp, uRresp;

    int compared   = 0;
    int mismatched = 0;
    int wrPulses   = 0;
    int rdPulses   = 0;
    int rBeats     = 0;

    axi4_noburst_slave_if #(.DW(32), .AW(32), .IW(4)) bus ();

    axi4_noburst_slave #(.DW(32), .AW(32), .IW(4)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_axi   (bus),
        .U_WADDR (uWaddr),
        .U_WDATA (uWdata),
        .U_WSTRB (uWstrb),
        .U_WRITE (uWrite),
        .U_WDONE (uWdone),
        .U_WRESP (uWresp),
        .U_RADDR (uRaddr),
        .U_READ  (uRead),
        .U_RDONE (uRdone),
        .U_RDATA (uRdata),
        .U_RRESP (uRresp)
    );

    always #5 clk = ~clk;

    // Independent tallies of strobes and R beats seen at the active edge
    always @(posedge clk) begin
        if (uWrite) wrPulses <= wrPulses + 1;
        if (uRead)  rdPulses <= rdPulses + 1;
        if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) rBeats <= rBeats + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.S_AXI_AWADDR  = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWLEN = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        uWdone = 1'b0; uWresp = 2'b00;
        uRdone = 1'b0; uRdata = '0; uRresp = 2'b00;
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus();
        tick(); tick();
        checkOutput("rst_awready", bus.S_AXI_AWREADY, 0);
        checkOutput("rst_wready",  bus.S_AXI_WREADY,  0);
        checkOutput("rst_arready", bus.S_AXI_ARREADY, 0);
        checkOutput("rst_bvalid",  bus.S_AXI_BVALID,  0);
        checkOutput("rst_rvalid",  bus.S_AXI_RVALID,  0);
        checkOutput("rst_uwrite",  uWrite, 0);
        checkOutput("rst_uread",   uRead,  0);
        resetn = 1'b1;
        tick();
        checkOutput("idle_awready", bus.S_AXI_AWREADY, 1);
        checkOutput("idle_wready",  bus.S_AXI_WREADY,  1);
        checkOutput("idle_arready", bus.S_AXI_ARREADY, 1);

        $display("[TB] test 1: AW then W two cycles later");
        bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_AWID = 4'h5; bus.S_AXI_AWLEN = 8'd0;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        checkOutput("t1_awready_low", bus.S_AXI_AWREADY, 0);
        checkOutput("t1_wready_high", bus.S_AXI_WREADY, 1);
        checkOutput("t1_no_write_yet", uWrite, 0);
        tick();
        bus.S_AXI_WDATA = 32'hA1B1C1D1; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WLAST = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        checkOutput("t1_uwrite", uWrite, 1);
        checkOutput("t1_uwaddr", uWaddr, 32'h0C);
        checkOutput("t1_uwdata", uWdata, 32'hA1B1C1D1);
        checkOutput("t1_uwstrb", uWstrb, 4'hF);
        tick();
        checkOutput("t1_uwrite_once", uWrite, 0);
        uWdone = 1'b1; uWresp = 2'b00;
        tick();
        uWdone = 1'b0;
        checkOutput("t1_bvalid", bus.S_AXI_BVALID, 1);
        checkOutput("t1_bresp",  bus.S_AXI_BRESP, 2'b00);
        checkOutput("t1_bid",    bus.S_AXI_BID, 4'h5);
        checkOutput("t1_awready_in_resp", bus.S_AXI_AWREADY, 0);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checkOutput("t1_bvalid_clear", bus.S_AXI_BVALID, 0);
        checkOutput("t1_awready_back", bus.S_AXI_AWREADY, 1);
        checkOutput("t1_wr_pulses", wrPulses, 1);

        $display("[TB] test 2: W before AW, B backpressure, same-cycle AW+W");
        bus.S_AXI_WDATA = 32'h11223344; bus.S_AXI_WSTRB = 4'h3; bus.S_AXI_WLAST = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        checkOutput("t2_wready_low", bus.S_AXI_WREADY, 0);
        checkOutput("t2_awready_high", bus.S_AXI_AWREADY, 1);
        bus.S_AXI_AWADDR = 32'h10; bus.S_AXI_AWID = 4'h9; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        checkOutput("t2_uwrite", uWrite, 1);
        checkOutput("t2_uwaddr", uWaddr, 32'h10);
        checkOutput("t2_uwdata", uWdata, 32'h11223344);
        checkOutput("t2_uwstrb", uWstrb, 4'h3);
        tick();
        uWdone = 1'b1; uWresp = 2'b01;
        tick();
        uWdone = 1'b0;
        bus.S_AXI_AWADDR = 32'h20; bus.S_AXI_AWID = 4'h2; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h55667788; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WLAST = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_bvalid", bus.S_AXI_BVALID, 1);
            checkOutput("t2_hold_bid", bus.S_AXI_BID, 4'h9);
            checkOutput("t2_hold_bresp", bus.S_AXI_BRESP, 2'b01);
            checkOutput("t2_hold_awready", bus.S_AXI_AWREADY, 0);
            tick();
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checkOutput("t2_bvalid_clear", bus.S_AXI_BVALID, 0);
        checkOutput("t2_awready_back", bus.S_AXI_AWREADY, 1);
        checkOutput("t2_wready_back", bus.S_AXI_WREADY, 1);
        checkOutput("t2_uwaddr_held", uWaddr, 32'h10);
        checkOutput("t2_wr_pulses", wrPulses, 2);
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        checkOutput("t2_same_uwrite", uWrite, 1);
        checkOutput("t2_same_uwaddr", uWaddr, 32'h20);
        checkOutput("t2_same_uwdata", uWdata, 32'h55667788);
        tick();
        uWdone = 1'b1; uWresp = 2'b00;
        tick();
        uWdone = 1'b0;
        checkOutput("t2_same_bid", bus.S_AXI_BID, 4'h2);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checkOutput("t2_same_bclear", bus.S_AXI_BVALID, 0);
        checkOutput("t2_wr_pulses_end", wrPulses, 3);

        $display("[TB] test 3: single read with RREADY toggling");
        bus.S_AXI_ARADDR = 32'h04; bus.S_AXI_ARID = 4'h3; bus.S_AXI_ARLEN = 8'd0;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        checkOutput("t3_uread", uRead, 1);
        checkOutput("t3_uraddr", uRaddr, 32'h04);
        checkOutput("t3_arready_low", bus.S_AXI_ARREADY, 0);
        tick();
        checkOutput("t3_uread_once", uRead, 0);
        tick(); tick();
        uRdone = 1'b1; uRdata = 32'hDEADBEEF; uRresp = 2'b00;
        tick();
        uRdone = 1'b0;
        checkOutput("t3_rvalid", bus.S_AXI_RVALID, 1);
        checkOutput("t3_rdata", bus.S_AXI_RDATA, 32'hDEADBEEF);
        checkOutput("t3_rid", bus.S_AXI_RID, 4'h3);
        checkOutput("t3_rlast", bus.S_AXI_RLAST, 1);
        checkOutput("t3_rresp", bus.S_AXI_RRESP, 2'b00);
        tick();
        checkOutput("t3_rvalid_hold", bus.S_AXI_RVALID, 1);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        checkOutput("t3_rvalid_clear", bus.S_AXI_RVALID, 0);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        tick();
        checkOutput("t3_r_beats", rBeats, 1);
        checkOutput("t3_rd_pulses", rdPulses, 1);
        checkOutput("t3_arready_back", bus.S_AXI_ARREADY, 1);

        $display("[TB] test 4: burst write and burst read rejected");
        bus.S_AXI_AWADDR = 32'h30; bus.S_AXI_AWID = 4'h7; bus.S_AXI_AWLEN = 8'd3;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        checkOutput("t4_drain_wready", bus.S_AXI_WREADY, 1);
        checkOutput("t4_drain_awready", bus.S_AXI_AWREADY, 0);
        bus.S_AXI_WDATA = 32'h1;
        tick();
        bus.S_AXI_WDATA = 32'h2;
        tick();
        bus.S_AXI_WDATA = 32'h3; bus.S_AXI_WLAST = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
        checkOutput("t4_bvalid", bus.S_AXI_BVALID, 1);
        checkOutput("t4_bresp", bus.S_AXI_BRESP, 2'b10);
        checkOutput("t4_bid", bus.S_AXI_BID, 4'h7);
        checkOutput("t4_wready_low", bus.S_AXI_WREADY, 0);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checkOutput("t4_bclear", bus.S_AXI_BVALID, 0);
        checkOutput("t4_no_uwrite", wrPulses, 3);

        bus.S_AXI_ARADDR = 32'h40; bus.S_AXI_ARID = 4'hA; bus.S_AXI_ARLEN = 8'd2;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        checkOutput("t4_r0_valid", bus.S_AXI_RVALID, 1);
        checkOutput("t4_r0_resp", bus.S_AXI_RRESP, 2'b10);
        checkOutput("t4_r0_data", bus.S_AXI_RDATA, 32'h0);
        checkOutput("t4_r0_last", bus.S_AXI_RLAST, 0);
        checkOutput("t4_r0_id", bus.S_AXI_RID, 4'hA);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        checkOutput("t4_r1_valid", bus.S_AXI_RVALID, 1);
        checkOutput("t4_r1_last", bus.S_AXI_RLAST, 0);
        tick();
        checkOutput("t4_r2_valid", bus.S_AXI_RVALID, 1);
        checkOutput("t4_r2_last", bus.S_AXI_RLAST, 1);
        checkOutput("t4_r2_resp", bus.S_AXI_RRESP, 2'b10);
        tick();
        bus.S_AXI_RREADY = 1'b0;
        checkOutput("t4_r_done", bus.S_AXI_RVALID, 0);
        checkOutput("t4_r_beats", rBeats, 4);
        checkOutput("t4_no_uread", rdPulses, 1);

        $display("[TB] test 5: concurrent read+write, reset mid-transaction");
        bus.S_AXI_AWADDR = 32'h50; bus.S_AXI_AWID = 4'h4; bus.S_AXI_AWLEN = 8'd0;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WLAST = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 32'h60; bus.S_AXI_ARID = 4'h6; bus.S_AXI_ARLEN = 8'd0;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        checkOutput("t5_uwrite", uWrite, 1);
        checkOutput("t5_uread", uRead, 1);
        tick();
        uRdone = 1'b1; uRdata = 32'h12345678;
        tick();
        uRdone = 1'b0;
        checkOutput("t5_rvalid", bus.S_AXI_RVALID, 1);
        checkOutput("t5_bvalid_wait", bus.S_AXI_BVALID, 0);
        resetn = 1'b0;
        tick();
        checkOutput("t5_rst_rvalid", bus.S_AXI_RVALID, 0);
        checkOutput("t5_rst_rdata", bus.S_AXI_RDATA, 32'h0);
        checkOutput("t5_rst_rid", bus.S_AXI_RID, 0);
        checkOutput("t5_rst_bvalid", bus.S_AXI_BVALID, 0);
        checkOutput("t5_rst_awready", bus.S_AXI_AWREADY, 0);
        checkOutput("t5_rst_arready", bus.S_AXI_ARREADY, 0);
        checkOutput("t5_rst_uwaddr", uWaddr, 32'h0);
        checkOutput("t5_rst_uraddr", uRaddr, 32'h0);
        resetn = 1'b1;
        uWdone = 1'b1; uWresp = 2'b10;
        tick();
        uWdone = 1'b0;
        checkOutput("t5_late_wdone_b", bus.S_AXI_BVALID, 0);
        tick();
        checkOutput("t5_late_wdone_b2", bus.S_AXI_BVALID, 0);
        checkOutput("t5_idle_awready", bus.S_AXI_AWREADY, 1);
        checkOutput("t5_idle_arready", bus.S_AXI_ARREADY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
